mux2_1_rr_arbiter: RTL and testbench
====================================

// Module: mux2_1_rr_arbiter
// PURPOSE
//  Round-robin packet arbiter that shares one output channel between two requesters
//  through the team's 2:1 mux datapath (Mux2_1).
//  Drives the mux select, locks a grant for a whole packet (valid/ready/last handshake)
//  and forces release on overlong packets.
//  Sits between two stream sources and a single downstream sink.
// PARAMETERS
//  DATA_W     8   width of in1_data / in2_data / out_data
//  MAX_BEATS  16  max beats per packet before forced release (>=2)
//  CNT_W      5   width of beat counter; must hold MAX_BEATS
// PORTS
//  sys_clk       in   1       system clock, all logic on rising edge
//  sys_rst       in   1       synchronous reset, active-high
//  in1_valid     in   1       requester 1 beat valid
//  in1_data      in   DATA_W  requester 1 beat data
//  in1_last      in   1       requester 1 final beat of packet
//  in1_ready     out  1       requester 1 beat accepted when valid&ready
//  in2_valid     in   1       requester 2 beat valid
//  in2_data      in   DATA_W  requester 2 beat data
//  in2_last      in   1       requester 2 final beat of packet
//  in2_ready     out  1       requester 2 beat accepted when valid&ready
//  out_valid     out  1       output beat valid
//  out_data      out  DATA_W  output beat data (mux output)
//  out_last      out  1       output final beat
//  out_ready     in   1       sink accepts beat when out_valid&out_ready
//  sel           out  1       registered mux select: 0=in1, 1=in2
//  busy          out  1       1 while in GRANT1/GRANT2
//  err_overlong  out  1       1-cycle pulse on forced release
// BEHAVIOUR
//  - Reset: state=IDLE, prio=in1, sel=0, beat_cnt=0, busy=0, err_overlong=0.
//    Combinational outputs in IDLE: out_valid=0, in1_ready=in2_ready=0.
//  - Reset mid-packet: IDLE on the next edge, partial packet abandoned, no error pulse.
//  - States: IDLE, GRANT1, GRANT2.
//    In GRANTx: out_valid=inx_valid, out_data=inx_data, out_last=inx_last,
//    inx_ready=out_ready, other ready=0.
//  - Arbitration function arb(v1,v2,prio):
//    - only one valid: grant it.
//    - both valid: grant the requester named by prio.
//    - none valid: IDLE.
//  - IDLE -> arb(...) next cycle. Arbitration latency is 1 cycle; no beat passes in IDLE.
//  - sel updates on the same edge as the state; sel holds its value in IDLE.
//  - Accept = out_valid & out_ready. Each accept increments beat_cnt.
//  - End of packet:
//    - Normal end: accept with out_last=1.
//    - Forced end: accept with beat_cnt==MAX_BEATS-1 and out_last=0.
//    - On either end: beat_cnt<=0 and prio<=other requester.
//    - Next state = arb(v1,v2,new prio), giving a direct zero-bubble handover if the
//      other requester is valid.
//  - Forced end: err_overlong=1 for that one cycle (registered, asserted the cycle after
//    the accept).
//  - Grant is never revoked except at end of packet or reset.
//    out_ready=0 stalls indefinitely with the grant held.
//  - busy = (state != IDLE), registered.
// TESTING
//  1. Reset, then in1 sends a 3-beat packet, out_ready=1 ->
//     sel=0, 3 beats out in order, last on beat 3, then IDLE with prio=in2.
//  2. Both valid from IDLE after reset ->
//     in1 granted first; in2 granted on the cycle after in1's last (no bubble); sel 0 -> 1.
//  3. in2 packet with out_ready toggling 1,0,0,1 ->
//     beats accepted only on ready cycles; grant and sel=1 held throughout.
//  4. in1 streams 20 beats without last, MAX_BEATS=16 ->
//     release after beat 16, err_overlong pulses once, in2 (valid) granted next.
//  5. sys_rst asserted mid-packet on GRANT2 ->
//     next edge: IDLE, sel=0, busy=0, ready outputs 0, prio=in1.

Source files
------------

// File: rtl/mux2_1_rr_arbiter.sv
// Two-requester round-robin packet arbiter steering one output channel through a 2:1 mux.
// The grant is held for a whole packet; it is released early once a packet reaches MAX_BEATS beats.

module mux2_1 #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// state  | meaning
// IDLE   | no grant; arbitrate the current requests, no beat passes
// GRANT1 | requester 1 owns the output until end of packet
// GRANT2 | requester 2 owns the output until end of packet
module mux2_1_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_last,
  output logic              in2_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy,
  output logic              err_overlong
);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

  state_t           state, state_nx;
  logic             prio, prio_nx;
  logic [CNT_W-1:0] beat_cnt;
  logic             accept, cnt_tc, pkt_end, forced;
  logic [DATA_W:0]  mux_y;

  // prio: 0 favours requester 1, 1 favours requester 2
  function automatic state_t arb(input logic v1, input logic v2, input logic p);
    if (v1 && v2) return p ? GRANT2 : GRANT1;
    if (v1)       return GRANT1;
    if (v2)       return GRANT2;
    return IDLE;
  endfunction

  mux2_1 #(.W(DATA_W + 1)) u_mux (
    .sel (sel),
    .a   ({in1_last, in1_data}),
    .b   ({in2_last, in2_data}),
    .y   (mux_y)
  );

  assign out_last = mux_y[DATA_W];
  assign out_data = mux_y[DATA_W-1:0];

  always_comb begin
    out_valid = 1'b0;
    in1_ready = 1'b0;
    in2_ready = 1'b0;
    case (state)
      GRANT1: begin
        out_valid = in1_valid;
        in1_ready = out_ready;
      end
      GRANT2: begin
        out_valid = in2_valid;
        in2_ready = out_ready;
      end
      default: ;
    endcase
  end

  assign accept  = out_valid & out_ready;
  assign cnt_tc  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign pkt_end = accept & (out_last | cnt_tc);
  assign forced  = accept & ~out_last & cnt_tc;
  // the requester that just finished loses priority to the other one
  assign prio_nx = pkt_end ? (state == GRANT1) : prio;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:           state_nx = arb(in1_valid, in2_valid, prio);
      GRANT1, GRANT2: if (pkt_end) state_nx = arb(in1_valid, in2_valid, prio_nx);
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      prio         <= 1'b0;
      sel          <= 1'b0;
      beat_cnt     <= '0;
      busy         <= 1'b0;
      err_overlong <= 1'b0;
    end else begin
      state        <= state_nx;
      prio         <= prio_nx;
      busy         <= (state_nx != IDLE);
      err_overlong <= forced;
      if (state_nx != IDLE) sel <= (state_nx == GRANT2);
      if (pkt_end)     beat_cnt <= '0;
      else if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux2_1_rr_arbiter.sv
// Bench for mux2_1_rr_arbiter: directed packet scenarios followed by random traffic,
// all checked cycle by cycle against a packet-level reference model.

module tb_mux2_1_rr_arbiter;
  localparam int DATA_W    = 8;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              in1_valid, in1_last, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              in2_valid, in2_last, in2_ready;
  logic [DATA_W-1:0] in2_data;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sel, busy, err_overlong;

  mux2_1_rr_arbiter #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .in1_valid    (in1_valid),
    .in1_data     (in1_data),
    .in1_last     (in1_last),
    .in1_ready    (in1_ready),
    .in2_valid    (in2_valid),
    .in2_data     (in2_data),
    .in2_last     (in2_last),
    .in2_ready    (in2_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .sel          (sel),
    .busy         (busy),
    .err_overlong (err_overlong)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t q1[$];
  beat_t q2[$];
  bit    gap1 = 0, gap2 = 0, rdy = 0;

  // reference model: owner 0 = nobody, 1/2 = requester; prio names the favoured requester
  int m_owner, m_prio, m_cnt, m_sel;
  bit m_err;
  int err_seen = 0;

  function automatic int arb(input bit v1, input bit v2, input int p);
    if (v1 && v2) return p;
    if (v1)       return 1;
    if (v2)       return 2;
    return 0;
  endfunction

  task automatic push_pkt(input int src, input int len, input bit has_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = DATA_W'($urandom);
      b.l = has_last && (i == len - 1);
      if (src == 1) q1.push_back(b);
      else          q2.push_back(b);
    end
  endtask

  task automatic step();
    bit                ev, er1, er2, el, acc;
    logic [DATA_W-1:0] ed;
    beat_t             bt;
    in1_valid = (q1.size() > 0) && !gap1;
    in2_valid = (q2.size() > 0) && !gap2;
    if (q1.size() > 0) begin in1_data = q1[0].d; in1_last = q1[0].l; end
    else begin in1_data = DATA_W'($urandom); in1_last = 1'($urandom); end
    if (q2.size() > 0) begin in2_data = q2[0].d; in2_last = q2[0].l; end
    else begin in2_data = DATA_W'($urandom); in2_last = 1'($urandom); end
    out_ready = rdy;
    @(negedge sys_clk);
    ev = 0; er1 = 0; er2 = 0; el = 0; ed = '0;
    if (m_owner == 1) begin ev = in1_valid; ed = in1_data; el = in1_last; er1 = out_ready; end
    if (m_owner == 2) begin ev = in2_valid; ed = in2_data; el = in2_last; er2 = out_ready; end
    chk("out_valid",    32'(out_valid),    32'(ev));
    chk("in1_ready",    32'(in1_ready),    32'(er1));
    chk("in2_ready",    32'(in2_ready),    32'(er2));
    chk("sel",          32'(sel),          32'(m_sel));
    chk("busy",         32'(busy),         32'(m_owner != 0));
    chk("err_overlong", 32'(err_overlong), 32'(m_err));
    if (ev) begin
      chk("out_data", 32'(out_data), 32'(ed));
      chk("out_last", 32'(out_last), 32'(el));
    end
    if (err_overlong === 1'b1) err_seen++;
    acc = ev && out_ready;
    if (sys_rst) begin
      m_owner = 0; m_prio = 1; m_sel = 0; m_cnt = 0; m_err = 0;
      q1.delete(); q2.delete();
    end else begin
      m_err = 0;
      if (acc) begin
        if (m_owner == 1) bt = q1.pop_front();
        else              bt = q2.pop_front();
      end
      if (m_owner == 0) begin
        m_owner = arb(in1_valid, in2_valid, m_prio);
      end else if (acc) begin
        m_cnt++;
        if (el || m_cnt == MAX_BEATS) begin
          m_err   = !el;
          m_cnt   = 0;
          m_prio  = 3 - m_owner;
          m_owner = arb(in1_valid, in2_valid, m_prio);
        end
      end
      if (m_owner != 0) m_sel = m_owner - 1;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q1.size() > 0 || q2.size() > 0); i++) step();
    step();
    step();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
  endtask

  initial begin
    int     err_base;
    beat_t  b;
    bit     rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    sys_rst   = 1'b1;
    in1_valid = 0; in1_data = '0; in1_last = 0;
    in2_valid = 0; in2_data = '0; in2_last = 0;
    out_ready = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    m_owner = 0; m_prio = 1; m_sel = 0; m_cnt = 0; m_err = 0;
    step();
    step();
    sys_rst = 1'b0;

    // single 3-beat packet from requester 1
    rdy = 1;
    for (int i = 0; i < 3; i++) begin
      b.d = DATA_W'(8'h11 * (i + 1));
      b.l = (i == 2);
      q1.push_back(b);
    end
    drain(20);

    // both requesting straight after reset: 1 first, then 2 with no bubble
    do_reset();
    push_pkt(1, 3, 1);
    push_pkt(2, 2, 1);
    drain(20);

    // requester 2 packet under a stalling sink
    push_pkt(2, 2, 1);
    rdy = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      rdy = rdy_pat[i];
      step();
    end
    rdy = 1;
    drain(20);

    // overlong packet from requester 1 while requester 2 waits
    err_base = err_seen;
    push_pkt(1, 19, 0);
    push_pkt(1, 1, 1);
    push_pkt(2, 2, 1);
    drain(80);
    chk("overlong_pulses", 32'(err_seen - err_base), 32'd1);

    // reset in the middle of a requester 2 packet
    push_pkt(2, 6, 0);
    repeat (4) step();
    do_reset();
    push_pkt(1, 2, 1);
    push_pkt(2, 2, 1);
    drain(20);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      gap1 = ($urandom % 4) == 0;
      gap2 = ($urandom % 4) == 0;
      rdy  = ($urandom % 4) != 0;
      if (q1.size() == 0 && ($urandom % 3) == 0) push_pkt(1, $urandom_range(1, 22), ($urandom % 5) != 0);
      if (q2.size() == 0 && ($urandom % 3) == 0) push_pkt(2, $urandom_range(1, 22), ($urandom % 5) != 0);
      sys_rst = ($urandom % 700) == 0;
      step();
    end
    sys_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
